// File: rtl/dmem_sram_like_slave_if.sv
// Bus bundle for the CPU's sram-like data port.
// The master (CPU) drives req/wr/size/addr/wdata plus the hold backpressure
// inject. The slave (data memory) returns addr_ok/data_ok/rdata/err.
//   req      request valid
//   wr       1=store, 0=load
//   size     0=byte, 1=half, 2=word, 3=reserved
//   addr     byte address
//   wdata    store data, lane-replicated by the CPU
//   hold     forces addr_ok low while set
//   addr_ok  request accepted this cycle when req && addr_ok
//   data_ok  one-cycle response pulse
//   rdata    load word, zero for stores and errors
//   err      misaligned / reserved-size flag
interface dmem_sram_like_slave_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hold;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, addr, wdata, hold,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, addr, wdata, hold,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/dmem_sram_like_slave.sv
// Data-memory responder for the CPU's sram-like data port.
// Services byte/half/word loads and stores with a fixed response latency and
// strictly in-order responses. Loads return the full RAM word. The CPU picks
// out the lanes it needs.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset (drops in-flight responses, keeps RAM)
//   bus  sram-like slave port (see dmem_sram_like_slave_if)
// Parameters:
//   ADDR_W   word-address bits, RAM depth = 2**ADDR_W words
//   LATENCY  cycles from the accept edge to the data_ok pulse (>=1)
//   QDEPTH   max accepted-but-unanswered requests (>=1)
module dmem_sram_like_slave #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 2
) (
    input logic                  clk,
    input logic                  rst,
    dmem_sram_like_slave_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);

    logic [CNT_W-1:0]   count_reg, count_next;
    logic [LATENCY-1:0] valid_reg;
    logic [LATENCY-1:0] load_reg;   // stage carries real load data (not store/error)
    logic [LATENCY-1:0] err_reg;
    logic [3:0]         be;
    logic               req_err;
    logic               accept;
    logic               store_en;
    logic               resp_valid;
    logic [ADDR_W-1:0]  word_idx;
    logic [31:0]        rdata_raw;

    // Upper address bits are intentionally ignored so addresses alias.
    assign word_idx = bus.addr[ADDR_W+1:2];

    generate
        if (ADDR_W < 30) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];
        end
    endgenerate

    // Byte enables and alignment check.
    always_comb begin
        be      = 4'b0000;
        req_err = 1'b0;
        case (bus.size)
            2'd0: be = 4'b0001 << bus.addr[1:0];
            2'd1: begin
                be      = bus.addr[1] ? 4'b1100 : 4'b0011;
                req_err = bus.addr[0];
            end
            2'd2: begin
                be      = 4'b1111;
                req_err = |bus.addr[1:0];
            end
            default: req_err = 1'b1;
        endcase
    end

    // A response leaving the pipeline this cycle still occupies its slot.
    assign bus.addr_ok = ~rst & ~bus.hold & (count_reg < QDEPTH_C);
    assign accept      = bus.req & bus.addr_ok;
    assign store_en    = accept & bus.wr & ~req_err;
    assign resp_valid  = valid_reg[LATENCY-1];

    always_comb begin
        count_next = count_reg;
        case ({accept, resp_valid})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // One RAM and one data delay line per byte lane, so each lane is a plain
    // byte-wide block RAM with its own write enable. The registered read on the
    // accept edge returns the old word, so a load never sees a store accepted
    // on the same edge, and later stores cannot disturb a captured load.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] ram [DEPTH];
            logic [7:0] pipe_reg [LATENCY];

            always_ff @(posedge clk) begin
                if (store_en && be[gi]) begin
                    ram[word_idx] <= bus.wdata[gi*8 +: 8];
                end
                if (accept) begin
                    pipe_reg[0] <= ram[word_idx];
                end
                for (int i = 1; i < LATENCY; i++) begin
                    pipe_reg[i] <= pipe_reg[i-1];
                end
            end

            assign rdata_raw[gi*8 +: 8] = pipe_reg[LATENCY-1];
        end
    endgenerate

    // Control side of the response pipeline; only this part is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            valid_reg <= '0;
            load_reg  <= '0;
            err_reg   <= '0;
        end else begin
            count_reg    <= count_next;
            valid_reg[0] <= accept;
            load_reg[0]  <= accept & ~bus.wr & ~req_err;
            err_reg[0]   <= accept & req_err;
            for (int i = 1; i < LATENCY; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                load_reg[i]  <= load_reg[i-1];
                err_reg[i]   <= err_reg[i-1];
            end
        end
    end

    assign bus.data_ok = resp_valid & ~rst;
    assign bus.rdata   = (bus.data_ok && load_reg[LATENCY-1]) ? rdata_raw : 32'h0;
    assign bus.err     = bus.data_ok & err_reg[LATENCY-1];
endmodule

// File: tb/tb_dmem_sram_like_slave.sv
// Self-checking bench for dmem_sram_like_slave. A reference model (word
// array + queue of expected responses tagged with their due cycle) predicts
// addr_ok, data_ok, rdata and err every cycle for directed and random traffic.
module tb_dmem_sram_like_slave;
    localparam int AW  = 4;
    localparam int LAT = 3;
    localparam int QD  = 2;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_sram_like_slave_if bus ();

    dmem_sram_like_slave #(.ADDR_W(AW), .LATENCY(LAT), .QDEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] model_mem [2**AW];
    rsp_t        rsp_q [$];
    logic        acc_model;
    logic        acc_seen;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Byte enables and error flag straight from the access-size rules.
    task automatic decode(input logic [1:0] sz, input logic [31:0] a,
                          output logic [3:0] be, output logic e);
        be = 4'b0000;
        e  = 1'b0;
        if (sz == 2'd0) begin
            be = 4'b0000;
            be[a[1:0]] = 1'b1;
        end else if (sz == 2'd1) begin
            be = (a[1] == 1'b1) ? 4'b1100 : 4'b0011;
            e  = (a[0] == 1'b1);
        end else if (sz == 2'd2) begin
            be = 4'b1111;
            e  = (a[1:0] != 2'b00);
        end else begin
            e = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic r, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic h, input logic rs);
        logic       exp_ok;
        logic [3:0] be;
        logic       e;
        rsp_t       f;
        rsp_t       n;
        int         idx;
        @(posedge clk);
        #1;
        bus.req   = r;
        bus.wr    = w;
        bus.size  = sz;
        bus.addr  = a;
        bus.wdata = wd;
        bus.hold  = h;
        rst       = rs;
        @(negedge clk);
        exp_ok = !rs && !h && (rsp_q.size() < QD);
        check_val("addr_ok", 32'(bus.addr_ok), 32'(exp_ok));
        acc_seen = r && bus.addr_ok;
        if (bus.data_ok) begin
            last_rdata = bus.rdata;
            last_err   = bus.err;
            $display("RSP cyc=%0d rdata=%h err=%0d", cyc, bus.rdata, bus.err);
        end
        if (!rs) begin
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                f = rsp_q.pop_front();
                check_val("data_ok", 32'(bus.data_ok), 32'd1);
                check_val("rdata", bus.rdata, f.rdata);
                check_val("err", 32'(bus.err), 32'(f.err));
            end else begin
                check_val("data_ok_idle", 32'(bus.data_ok), 32'd0);
            end
        end
        acc_model = 1'b0;
        if (rs) begin
            rsp_q.delete();
        end else if (r && exp_ok) begin
            acc_model = 1'b1;
            decode(sz, a, be, e);
            idx     = int'(a[AW+1:2]);
            n.due   = cyc + LAT;
            n.err   = e;
            n.rdata = (e || w) ? 32'h0 : model_mem[idx];
            rsp_q.push_back(n);
            if (w && !e) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
                end
            end
            $display("REQ cyc=%0d wr=%0d size=%0d addr=%h wdata=%h", cyc, w, sz, a, wd);
        end
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        repeat (LAT + 1) idle();
    endtask

    // Retry a request until the model says it was accepted (bounded).
    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
        int tries = 0;
        acc_model = 1'b0;
        while (!acc_model && tries < 20) begin
            step(1'b1, w, sz, a, wd, 1'b0, 1'b0);
            tries++;
        end
        check_val("issue_accepted", 32'(acc_model), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acc_cnt;
        logic [31:0] a;
        logic [1:0]  sz;
        bus.req   = 1'b0;
        bus.wr    = 1'b0;
        bus.size  = 2'd0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        bus.hold  = 1'b0;

        // Reset, with req asserted to show nothing is accepted.
        repeat (3) step(1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 1'b1);
        idle();
        check_val("rst_data_ok", 32'(bus.data_ok), 32'd0);
        check_val("rst_rdata", bus.rdata, 32'h0);
        check_val("rst_err", 32'(bus.err), 32'd0);

        // Fill the RAM so every later load has a known value.
        for (int i = 0; i < 2**AW; i++) issue(1'b1, 2'd2, 32'(i * 4), $urandom());
        drain();

        // T1: word store then word load.
        issue(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 32'h10, 32'h0);
        drain();
        check_val("t1_rdata", last_rdata, 32'hDEADBEEF);
        check_val("t1_err", 32'(last_err), 32'd0);

        // T2: byte store into lane 1, then word load.
        issue(1'b1, 2'd0, 32'h11, 32'hABABABAB);
        issue(1'b0, 2'd2, 32'h10, 32'h0);
        drain();
        check_val("t2_rdata", last_rdata, 32'hDEADABEF);

        // T3: misaligned half load errors, RAM untouched.
        issue(1'b0, 2'd1, 32'h13, 32'h0);
        drain();
        check_val("t3_err", 32'(last_err), 32'd1);
        check_val("t3_rdata", last_rdata, 32'h0);
        issue(1'b0, 2'd2, 32'h10, 32'h0);
        drain();
        check_val("t3_reload", last_rdata, 32'hDEADABEF);

        // T4: req held high with loads; the queue fills and blocks.
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 2'd2, 32'(i * 4), 32'h0, 1'b0, 1'b0);
            if (acc_seen) acc_cnt++;
        end
        check_val("t4_accepts", 32'(acc_cnt), 32'd2);
        step(1'b1, 1'b0, 2'd2, 32'h8, 32'h0, 1'b0, 1'b0);
        check_val("t4_reaccept", 32'(acc_seen), 32'd1);
        drain();

        // T5: hold blocks acceptance, release accepts immediately.
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 2'd2, 32'h4, 32'h0, 1'b1, 1'b0);
            if (acc_seen) acc_cnt++;
        end
        check_val("t5_hold_accepts", 32'(acc_cnt), 32'd0);
        step(1'b1, 1'b0, 2'd2, 32'h4, 32'h0, 1'b0, 1'b0);
        check_val("t5_release", 32'(acc_seen), 32'd1);
        drain();

        // T6: reset with two requests in flight; stored data survives.
        issue(1'b1, 2'd2, 32'h20, 32'h12345678);
        drain();
        issue(1'b0, 2'd2, 32'h20, 32'h0);
        issue(1'b0, 2'd2, 32'h10, 32'h0);
        step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        repeat (LAT + 2) idle();
        last_rdata = 32'hFFFFFFFF;
        issue(1'b0, 2'd2, 32'h20, 32'h0);
        drain();
        check_val("t6_after_rst", last_rdata, 32'h12345678);

        // Random traffic with aliasing addresses, hold and occasional reset.
        for (int n = 0; n < 600; n++) begin
            a = $urandom();
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), sz, a, $urandom(),
                 $urandom_range(0, 6) == 0, $urandom_range(0, 99) == 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
